// File: rtl/lb_uart_pkg.sv
// rtl/lb_uart_pkg.sv - shared types, constants and helpers for the buffered UART transmitter
package lb_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } tx_state_e;

  localparam logic [1:0] LEN_5 = 2'b00;
  localparam logic [1:0] LEN_6 = 2'b01;
  localparam logic [1:0] LEN_7 = 2'b10;
  localparam logic [1:0] LEN_8 = 2'b11;

  localparam logic LINE_MARK  = 1'b1;
  localparam logic LINE_SPACE = 1'b0;

  function automatic logic [3:0] len_to_bits(input logic [1:0] code);
    case (code)
      LEN_5:   return 4'd5;
      LEN_6:   return 4'd6;
      LEN_7:   return 4'd7;
      LEN_8:   return 4'd8;
      default: return 4'd8;
    endcase
  endfunction

  // Keeps only the bits that will actually go on the line, so parity sees them alone.
  function automatic logic [7:0] len_mask(input logic [1:0] code);
    case (code)
      LEN_5:   return 8'h1F;
      LEN_6:   return 8'h3F;
      LEN_7:   return 8'h7F;
      LEN_8:   return 8'hFF;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/lb_sync_fifo.sv
// rtl/lb_sync_fifo.sv - synchronous show-ahead FIFO with occupancy output
module lb_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] count;
  logic             push_ok;
  logic             pop_ok;

  // Eligibility uses the pre-edge flags: a pop in the same cycle does not make room.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign full    = (count == LVL_W'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign rdata   = mem[rd_ptr];

  // Storage array; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  // Pointers and occupancy; depth is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + LVL_W'(1);
        2'b01:   count <= count - LVL_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lb_uart_tx_fifo_param.sv
// rtl/lb_uart_tx_fifo_param.sv - FIFO-fronted UART transmitter with runtime framing and break
module lb_uart_tx_fifo_param
  import lb_uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int BAUD_W     = 20,
  parameter int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs,
  input  logic              we,
  input  logic [7:0]        data,
  input  logic [1:0]        data_len,
  input  logic              parity_en,
  input  logic              odd_n_even,
  input  logic              two_stop,
  input  logic              brk,
  input  logic [BAUD_W-1:0] baud_val,
  input  logic              ovf_clr,
  output logic              tx,
  output logic              txrdy,
  output logic              tx_busy,
  output logic              tx_done,
  output logic [LVL_W-1:0]  level,
  output logic              overflow
);

  tx_state_e         state, state_d;
  logic [BAUD_W-1:0] cnt, cnt_d;
  logic [2:0]        bit_idx, bit_idx_d;
  logic [7:0]        sh, sh_d;
  logic              guard, guard_d;
  logic              tx_d, done_d;
  logic              pop, dispatch, bit_end;
  logic              full, empty;
  logic [7:0]        rdata;
  logic [3:0]        nbits_l;
  logic              par_en_l, par_l, two_stop_l;

  lb_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH), .LVL_W(LVL_W)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (cs && we),
    .pop   (pop),
    .wdata (data),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign txrdy   = !full;
  assign tx_busy = (state != ST_IDLE);
  assign bit_end = (cnt == '0);

  // Next-state, line level and frame bookkeeping; dispatch picks what follows a frame or guard.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    bit_idx_d = bit_idx;
    sh_d      = sh;
    guard_d   = guard;
    tx_d      = tx;
    pop       = 1'b0;
    dispatch  = 1'b0;
    case (state)
      ST_IDLE: dispatch = 1'b1;
      ST_START: begin
        if (bit_end) begin
          state_d   = ST_DATA;
          bit_idx_d = '0;
          tx_d      = sh[0];
          cnt_d     = baud_val;
        end else cnt_d = cnt - BAUD_W'(1);
      end
      ST_DATA: begin
        if (bit_end) begin
          cnt_d = baud_val;
          if ({1'b0, bit_idx} == nbits_l - 4'd1) begin
            bit_idx_d = '0;
            if (par_en_l) begin
              state_d = ST_PARITY;
              tx_d    = par_l;
            end else begin
              state_d = ST_STOP;
              tx_d    = LINE_MARK;
            end
          end else begin
            bit_idx_d = bit_idx + 3'd1;
            sh_d      = sh >> 1;
            tx_d      = sh[1];
          end
        end else cnt_d = cnt - BAUD_W'(1);
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d   = ST_STOP;
          bit_idx_d = '0;
          tx_d      = LINE_MARK;
          cnt_d     = baud_val;
        end else cnt_d = cnt - BAUD_W'(1);
      end
      ST_STOP: begin
        if (bit_end) begin
          if (bit_idx[0] == two_stop_l) dispatch = 1'b1;
          else begin
            bit_idx_d = 3'd1;
            tx_d      = LINE_MARK;
            cnt_d     = baud_val;
          end
        end else cnt_d = cnt - BAUD_W'(1);
      end
      ST_BREAK: begin
        if (guard) begin
          if (bit_end) dispatch = 1'b1;
          else cnt_d = cnt - BAUD_W'(1);
        end else if (!brk) begin
          guard_d = 1'b1;
          tx_d    = LINE_MARK;
          cnt_d   = baud_val;
        end else tx_d = LINE_SPACE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (dispatch) begin
      guard_d   = 1'b0;
      bit_idx_d = '0;
      if (brk) begin
        state_d = ST_BREAK;
        tx_d    = LINE_SPACE;
      end else if (!empty) begin
        pop     = 1'b1;
        state_d = ST_START;
        tx_d    = LINE_SPACE;
        cnt_d   = baud_val;
        sh_d    = rdata & len_mask(data_len);
      end else begin
        state_d = ST_IDLE;
        tx_d    = LINE_MARK;
      end
    end
    done_d = (state_d == ST_STOP) && (cnt_d == '0) && (bit_idx_d[0] == two_stop_l);
  end

  // Datapath and line registers; every output is taken from here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      sh       <= '0;
      guard    <= 1'b0;
      tx       <= LINE_MARK;
      tx_done  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      bit_idx <= bit_idx_d;
      sh      <= sh_d;
      guard   <= guard_d;
      tx      <= tx_d;
      tx_done <= done_d;
      if (cs && we && full) overflow <= 1'b1;
      else if (ovf_clr)     overflow <= 1'b0;
    end
  end

  // Frame configuration is captured with the word so mid-frame changes wait for the next frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      nbits_l    <= 4'd8;
      par_en_l   <= 1'b0;
      par_l      <= 1'b0;
      two_stop_l <= 1'b0;
    end else if (pop) begin
      nbits_l    <= len_to_bits(data_len);
      par_en_l   <= parity_en;
      par_l      <= (^(rdata & len_mask(data_len))) ^ odd_n_even;
      two_stop_l <= two_stop;
    end
  end

endmodule

// File: doc/lb_uart_tx_fifo_param.md
Name: lb_uart_tx_fifo_param

Overview:
Parametrised, buffered UART transmitter for the PicoBlaze local bus: the next generation of the FIFO-fronted Tx block.
- Adds runtime data length (5-8 bits), 1 or 2 stop bits, line break generation, FIFO fill level, a sticky overflow flag and a per-frame done pulse.
- FIFO depth and baud-counter width are compile-time parameters.
- Sits between the bus decode (cs/we) and the tx pin; drives the pin directly, with no tri-state.

Parameters:
FIFO_DEPTH, 16, number of FIFO entries; power of two, at least 2.
BAUD_W, 20, width of baud_val.
LVL_W, $clog2(FIFO_DEPTH+1), width of level (derived; do not override).

Ports:
clk  in  1  system clock; all logic on its rising edge.
reset  in  1  asynchronous, active-low reset.
cs  in  1  chip select; qualifies we.
we  in  1  write strobe; push accepted when cs&we&!full.
data  in  8  write data; bits above the selected length are ignored.
data_len  in  2  00=5, 01=6, 10=7, 11=8 data bits.
parity_en  in  1  1 = append parity bit.
odd_n_even  in  1  1 = odd parity, 0 = even parity.
two_stop  in  1  1 = two stop bits.
brk  in  1  break request.
baud_val  in  BAUD_W  clocks per bit minus 1.
ovf_clr  in  1  clears overflow.
tx  out  1  serial line; idle high.
txrdy  out  1  1 = FIFO not full.
tx_busy  out  1  1 = state other than IDLE.
tx_done  out  1  one-cycle pulse on the last cycle of each frame's final stop bit.
level  out  LVL_W  FIFO occupancy.
overflow  out  1  sticky; set by a write attempted while full.

Behaviour:
- Reset (async assert, sync release): tx=1, txrdy=1, tx_busy=0, tx_done=0, level=0, overflow=0, FSM=IDLE, FIFO pointers=0.
- Reset mid-frame aborts the frame immediately; tx=1 and FIFO contents are discarded.
- All outputs are registered or derived from registers only.
- FIFO: synchronous, show-ahead.
  - Push at edge E makes the word visible and updates level at E+1.
  - Write while full is dropped, level unchanged, overflow set.
  - Write and pop in the same cycle leave level unchanged.
  - Push eligibility uses the pre-edge full flag; a same-cycle pop does not free space.
  - ovf_clr and a new overflow event in the same cycle: overflow stays set.
- Bit timing: a bit lasts baud_val+1 clocks. A down-counter reloads at each bit start. baud_val=0 gives 1 clock per bit.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE: brk=1 -> BREAK. Else, FIFO non-empty -> pop, latch word and all config, -> START. A write accepted at edge E drives tx low from edge E+1.
  - START: tx=0 for one bit -> DATA.
  - DATA: LSB first; bit counter runs to the latched length -> PARITY if parity_en, else STOP.
  - PARITY: even parity = XOR of transmitted data bits; odd parity = its inverse.
  - STOP: tx=1 for 1 or 2 bits. tx_done pulses on the final cycle. Then the next frame's START begins the following cycle if the FIFO is non-empty and brk=0: no idle gap between frames.
  - BREAK: tx=0 while brk=1; the FIFO is not drained. On brk=0, drive tx=1 for one full bit period (mark guard) -> IDLE.
- brk asserted mid-frame: the current frame completes normally, then BREAK.
- Config inputs changing mid-frame have no effect until the next frame start.
- baud_val is sampled at every bit start.

Decomposition:
- Package lb_uart_pkg holds:
  - FSM state enum;
  - data_len code constants and a len-to-bit-count function;
  - mark/space line level constants.
- Sub-module lb_sync_fifo: parameters WIDTH and DEPTH; ports push, pop, wdata, rdata, full, empty, level.
- FSM and shifter stay in the top module.

Test Plan:
1. FIFO_DEPTH=4, baud_val=3, 8N1: write 0xA5 -> tx low from next edge. Bit sequence is 0,1,0,1,0,0,1,0,1,1, each bit 4 clocks. tx_done pulses on clock 40. tx_busy falls next cycle. level returns to 0.
2. 8E1 then 8O1 with 0xA5 (four ones) -> parity bit 0, then 1. Frame is 11 bits, 44 clocks each. 7E2 with 0x55 -> 7 data bits, parity 0, two stop bits, frame 44 clocks.
3. 5N1 with 0xFF -> exactly five 1 data bits, frame 28 clocks. Bits 7:5 are never transmitted.
4. Hold brk=1 from idle, write 5 words -> tx stays 0, level=4, txrdy=0, overflow=1. Release brk -> tx=1 for 4 clocks, then 4 frames back-to-back with no gap. ovf_clr -> overflow=0.
5. Write+pop same cycle with level=2 -> level stays 2. Write while full with simultaneous pop -> write dropped, overflow set, level 3.
6. Assert reset mid-DATA -> tx=1 and level=0 immediately. No tx_done pulse. After release, a new write transmits normally.
